// File: rtl/demux_stream.sv
// Registered 1-to-N stream demultiplexer with one-entry output slots per channel.
// Optional broadcast input enabled by defining DEMUX_STREAM_BCAST_EN.
module demux_stream #(
  parameter int unsigned DW   = 8,
  parameter int unsigned N    = 8,
  parameter int unsigned SELW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [SELW-1:0] in_sel,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic [N*DW-1:0] out_data,
  output logic [15:0]     drop_cnt
`ifdef DEMUX_STREAM_BCAST_EN
  ,
  input  logic            in_bcast
`endif
);

  localparam logic [SELW:0] NUM_CH = (SELW+1)'(N);

  logic [N-1:0]    valid_q, valid_d;
  logic [N*DW-1:0] data_q, data_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic [N-1:0]    free;
  logic [N-1:0]    sel_hit;
  logic [N-1:0]    load;
  logic            in_range;
  logic            bcast;
  logic            ready_c;
  logic            xfer;

  always_comb begin
    free = ~valid_q | out_ready;

    sel_hit = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sel_hit[k] = (in_sel == SELW'(k));
    end
    in_range = {1'b0, in_sel} < NUM_CH;

    bcast = 1'b0;
`ifdef DEMUX_STREAM_BCAST_EN
    bcast = in_bcast;
`endif

    // Out-of-range selects are always accepted so they can be discarded.
    if (bcast) begin
      ready_c = &free;
    end else if (in_range) begin
      ready_c = |(sel_hit & free);
    end else begin
      ready_c = 1'b1;
    end
    in_ready = ~rst & ready_c;
    xfer     = in_valid & in_ready;

    load = '0;
    if (xfer) begin
      if (bcast) begin
        load = '1;
      end else if (in_range) begin
        load = sel_hit;
      end
    end

    valid_d = (valid_q & ~out_ready) | load;

    data_d = data_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (load[k]) begin
        data_d[k*DW +: DW] = in_data;
      end
    end

    drop_cnt_d = drop_cnt_q;
    if (xfer && !bcast && !in_range && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      data_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: an N=8 and an N=6 instance share one stimulus stream,
// each compared every cycle against a slot-level model plus literal expectations.
module tb_demux_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic [7:0]  ordy;
  logic        rdy_a, rdy_b;
  logic [7:0]  ov_a;
  logic [5:0]  ov_b;
  logic [63:0] od_a;
  logic [47:0] od_b;
  logic [15:0] dc_a, dc_b;
`ifdef DEMUX_STREAM_BCAST_EN
  logic        in_bcast = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: per instance, which slots hold a word, the last word per slot, drop count.
  bit         held [2][8];
  logic [7:0] mdat [2][8];
  int         mdrop[2];

  always #5 clk = ~clk;

  demux_stream #(.DW(8), .N(8), .SELW(3)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
    .in_data(in_data), .in_sel(in_sel), .out_valid(ov_a), .out_ready(ordy),
    .out_data(od_a), .drop_cnt(dc_a)
`ifdef DEMUX_STREAM_BCAST_EN
    , .in_bcast(in_bcast)
`endif
  );

  demux_stream #(.DW(8), .N(6), .SELW(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
    .in_data(in_data), .in_sel(in_sel), .out_valid(ov_b), .out_ready(ordy[5:0]),
    .out_data(od_b), .drop_cnt(dc_b)
`ifdef DEMUX_STREAM_BCAST_EN
    , .in_bcast(in_bcast)
`endif
  );

  function automatic int nch(int i);
    return (i == 0) ? 8 : 6;
  endfunction

  function automatic bit is_bcast();
`ifdef DEMUX_STREAM_BCAST_EN
    return in_bcast;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_ready(int i);
    if (rst) return 1'b0;
    if (is_bcast()) begin
      for (int k = 0; k < nch(i); k++)
        if (held[i][k] && !ordy[k]) return 1'b0;
      return 1'b1;
    end
    if (int'(in_sel) >= nch(i)) return 1'b1;
    return !held[i][in_sel] || ordy[in_sel];
  endfunction

  function automatic logic [63:0] exp_valid(int i);
    logic [63:0] v = '0;
    for (int k = 0; k < nch(i); k++) v[k] = held[i][k];
    return v;
  endfunction

  function automatic logic [63:0] exp_data(int i);
    logic [63:0] d = '0;
    for (int k = 0; k < nch(i); k++) d[k*8 +: 8] = mdat[i][k];
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit r[2];
    for (int i = 0; i < 2; i++) r[i] = exp_ready(i);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int k = 0; k < 8; k++) begin
          held[i][k] = 1'b0;
          mdat[i][k] = '0;
        end
        mdrop[i] = 0;
      end else begin
        for (int k = 0; k < nch(i); k++)
          if (held[i][k] && ordy[k]) held[i][k] = 1'b0;
        if (in_valid && r[i]) begin
          if (is_bcast()) begin
            for (int k = 0; k < nch(i); k++) begin
              held[i][k] = 1'b1;
              mdat[i][k] = in_data;
            end
          end else if (int'(in_sel) < nch(i)) begin
            held[i][in_sel] = 1'b1;
            mdat[i][in_sel] = in_data;
          end else if (mdrop[i] < 65535) begin
            mdrop[i]++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready_a",  64'(rdy_a), 64'(exp_ready(0)));
      chk("in_ready_b",  64'(rdy_b), 64'(exp_ready(1)));
      chk("out_valid_a", 64'(ov_a),  exp_valid(0));
      chk("out_valid_b", 64'(ov_b),  exp_valid(1));
      chk("out_data_a",  od_a,       exp_data(0));
      chk("out_data_b",  64'(od_b),  exp_data(1));
      chk("drop_cnt_a",  64'(dc_a),  64'(mdrop[0]));
      chk("drop_cnt_b",  64'(dc_b),  64'(mdrop[1]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    ordy = 8'hFF;
    drive(1'b0, 3'd0, 8'h00);
    cyc();
    cyc();
    chk_en = 1'b1;
    rst = 1'b0;
    chk("lit_reset_valid_a", 64'(ov_a), 64'h0);
    chk("lit_reset_drop_b",  64'(dc_b), 64'h0);

    // Back-to-back sweep across all channels
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 3'(k), 8'hA0 + 8'(k));
      #1 chk("lit_sweep_ready_a", 64'(rdy_a), 64'h1);
      cyc();
    end
    drive(1'b0, 3'd0, 8'h00);
    chk("lit_sweep_valid_a", 64'(ov_a), 64'h80);
    chk("lit_sweep_data_a",  od_a, 64'hA7A6A5A4A3A2A1A0);
    chk("lit_sweep_data_b",  64'(od_b), 64'hA5A4A3A2A1A0);
    chk("lit_sweep_drop_b",  64'(dc_b), 64'd2);
    chk("lit_model_drop_b",  64'(mdrop[1]), 64'd2);
    cyc();
    chk("lit_sweep_drained_a", 64'(ov_a), 64'h0);

    // Stalled channel 3 blocks only words addressed to it
    ordy = 8'hF7;
    drive(1'b1, 3'd3, 8'h31);
    cyc();
    drive(1'b1, 3'd3, 8'h32);
    #1 chk("lit_stall_ready_a", 64'(rdy_a), 64'h0);
    chk("lit_stall_ready_b", 64'(rdy_b), 64'h0);
    cyc();
    drive(1'b1, 3'd5, 8'h51);
    #1 chk("lit_pass5_ready_a", 64'(rdy_a), 64'h1);
    cyc();
    chk("lit_stall_valid_a", 64'(ov_a), 64'h28);
    chk("lit_stall_data3_a", 64'(od_a[31:24]), 64'h31);
    drive(1'b1, 3'd3, 8'h32);
    ordy = 8'hFF;
    #1 chk("lit_release_ready_a", 64'(rdy_a), 64'h1);
    cyc();
    chk("lit_release_valid_a", 64'(ov_a), 64'h08);
    chk("lit_release_data3_a", 64'(od_a[31:24]), 64'h32);
    drive(1'b0, 3'd0, 8'h00);
    cyc();

    // Out-of-range selects on the N=6 instance
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive(1'b1, 3'd6, 8'h01);
    #1 chk("lit_drop_ready_b", 64'(rdy_b), 64'h1);
    cyc();
    drive(1'b1, 3'd7, 8'h02);
    cyc();
    drive(1'b1, 3'd6, 8'h03);
    cyc();
    drive(1'b0, 3'd0, 8'h00);
    chk("lit_drop_cnt_b",   64'(dc_b), 64'd3);
    chk("lit_drop_valid_b", 64'(ov_b), 64'h0);
    chk("lit_model_drop3",  64'(mdrop[1]), 64'd3);

    // Zero-bubble refill of a full channel 2
    ordy = 8'hFB;
    drive(1'b1, 3'd2, 8'h22);
    cyc();
    drive(1'b1, 3'd2, 8'h5A);
    ordy = 8'hFF;
    #1 chk("lit_refill_ready_a", 64'(rdy_a), 64'h1);
    cyc();
    chk("lit_refill_valid2_a", 64'(ov_a[2]), 64'h1);
    chk("lit_refill_data2_a",  64'(od_a[23:16]), 64'h5A);
    drive(1'b0, 3'd0, 8'h00);
    cyc();

    // Reset while slots 1 and 4 hold words
    ordy = 8'h00;
    drive(1'b1, 3'd1, 8'h11);
    cyc();
    drive(1'b1, 3'd4, 8'h44);
    cyc();
    chk("lit_prerst_valid_a", 64'(ov_a), 64'h12);
    chk("lit_prerst_valid_b", 64'(ov_b), 64'h12);
    rst = 1'b1;
    drive(1'b1, 3'd0, 8'hFF);
    #1 chk("lit_rst_ready_a", 64'(rdy_a), 64'h0);
    cyc();
    rst = 1'b0;
    drive(1'b0, 3'd0, 8'h00);
    chk("lit_rst_valid_a", 64'(ov_a), 64'h0);
    chk("lit_rst_data_a",  od_a, 64'h0);
    chk("lit_rst_drop_b",  64'(dc_b), 64'h0);
    ordy = 8'hFF;

    // Long drop run to reach saturation
    drive(1'b1, 3'd7, 8'h77);
    repeat (65540) cyc();
    drive(1'b0, 3'd0, 8'h00);
    chk("lit_sat_drop_b",  64'(dc_b), 64'hFFFF);
    chk("lit_sat_model_b", 64'(mdrop[1]), 64'hFFFF);
    chk("lit_sat_drop_a",  64'(dc_a), 64'h0);
    cyc();

`ifdef DEMUX_STREAM_BCAST_EN
    ordy = 8'hFE;
    drive(1'b1, 3'd0, 8'h0F);
    cyc();
    in_bcast = 1'b1;
    drive(1'b1, 3'd5, 8'hC3);
    #1 chk("lit_bcast_stall_ready_a", 64'(rdy_a), 64'h0);
    cyc();
    ordy = 8'hFF;
    #1 chk("lit_bcast_ready_a", 64'(rdy_a), 64'h1);
    cyc();
    in_bcast = 1'b0;
    drive(1'b0, 3'd0, 8'h00);
    chk("lit_bcast_valid_a", 64'(ov_a), 64'hFF);
    chk("lit_bcast_data_a",  od_a, {8{8'hC3}});
    chk("lit_bcast_valid_b", 64'(ov_b), 64'h3F);
    chk("lit_bcast_drop_b",  64'(dc_b), 64'hFFFF);
    cyc();
`endif

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
# demux_stream

Registered, parametrised 1-to-N stream demultiplexer. It accepts one DW-bit word per cycle on a valid/ready input and steers it by `in_sel` into one of N independent one-entry output slots, each with its own valid/ready handshake. It sits between a single producer and N consumers and replaces latch-style combinational demuxing with clocked, back-pressure-aware routing. Out-of-range selects are absorbed and counted.

## Interface
- `DW`, 8, data width in bits
- `N`, 8, number of output channels (2..16)
- `SELW`, 3, select width; N ≤ 2^SELW
- `clk`  input  1  clock, all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `in_valid`  input  1  input word present
- `in_ready`  output  1  block can accept the input word this cycle
- `in_data`  input  DW  input word
- `in_sel`  input  SELW  destination channel index
- `out_valid`  output  N  bit k: channel k slot holds a word
- `out_ready`  input  N  bit k: consumer k takes the word this cycle
- `out_data`  output  N*DW  channel k word at bits [k*DW +: DW]
- `drop_cnt`  output  16  saturating count of words dropped for out-of-range select
- `in_bcast`  input  1  broadcast request; present only with `DEMUX_STREAM_BCAST_EN`

## Operation
- Input transfer when `in_valid && in_ready` on a rising edge.
- Channel k is free when `!out_valid[k] || out_ready[k]`; a slot drains and refills in the same cycle.
- `in_sel < N`: `in_ready` = free(`in_sel`). On transfer, slot `in_sel` loads `in_data` and `out_valid[in_sel]` is set.
- `in_sel >= N`: `in_ready` = 1. The word is accepted and discarded, and `drop_cnt` increments, holding at 16'hFFFF.
- `in_ready` is combinational from `in_sel`, `out_valid` and `out_ready`. It does not depend on `in_valid`.
- A slot that is drained (`out_valid[k] && out_ready[k]`) and not reloaded in the same cycle clears `out_valid[k]`. `out_data` for that slot holds its last value.
- Channels are independent. A stalled channel k blocks the input only while `in_sel == k`. Other channels keep draining.
- Words for the same channel leave in arrival order. There is no ordering guarantee across channels.
- `out_data` for a slot is stable while its `out_valid` is high and `out_ready` is low.

## Timing
- Reset: `out_valid` = 0, `out_data` = 0, `drop_cnt` = 0. During reset, `in_ready` = 0 and no transfer occurs.
- Reset mid-operation discards all held words on the next edge. The `drop_cnt` value is lost.
- Latency: a word accepted at edge t appears with `out_valid[k]` high after edge t. It can be consumed at edge t+1 at the earliest.
- Throughput: one word per cycle sustained when the addressed channels' `out_ready` are held high.
- A full channel with `out_ready[k]` high and `in_sel == k` accepts a new word in the same cycle. There is no bubble.
- `in_valid` low: no state change except drains.

## Configuration
- `DEMUX_STREAM_BCAST_EN` defined:
  - Adds the `in_bcast` port.
  - With `in_bcast` high, `in_ready` = AND of free(k) over all k, and `in_sel` is ignored.
  - On transfer, every slot loads `in_data` and all `out_valid` bits set. `drop_cnt` is unchanged.
  - With `in_bcast` low, behaviour is identical to the undefined case.
- Undefined: there is no `in_bcast` port and no broadcast logic.

## Test plan
- Reset, then DW=8, N=8, all `out_ready`=1, send 8'hA0..8'hA7 with `in_sel`=0..7 back-to-back. Expect each `out_data[k]` = 8'hA0+k with `out_valid[k]` pulsing one cycle, `in_ready` constantly 1, and `drop_cnt`=0.
- Hold `out_ready[3]`=0 and send two words to channel 3. Expect the first held with `in_ready`=0 on the second. Meanwhile, words to channel 5 pass. Raise `out_ready[3]`: the first word drains and the second loads the same edge.
- N=6, SELW=3, send `in_sel`=6 and 7, three words total. Expect `in_ready`=1, no `out_valid` change, and `drop_cnt`=3. Preload the counter near 16'hFFFF via long run and confirm saturation.
- Channel 2 full, `out_ready[2]`=1, and `in_sel`=2 with 8'h5A present. Expect zero-bubble refill: `out_valid[2]` stays 1 and data becomes 8'h5A.
- Assert `rst` for one cycle while slots 1 and 4 are valid. Expect all `out_valid`=0, `out_data`=0, and `drop_cnt`=0 next cycle.
- With `DEMUX_STREAM_BCAST_EN`: `in_bcast`=1 and data 8'hC3 while channel 0 is stalled. Expect `in_ready`=0. Release it and expect all 8 slots to hold 8'hC3 with all `out_valid` set.
